// File: rtl/port_wrr_scheduler.sv
// Per-output-port packet scheduler: picks one of NQ priority queues per packet,
// in weighted round robin or strict priority, and locks the grant until end of packet.
module wrr_credit_cell #(
  parameter logic [3:0] W = 4'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_reload,
  input  logic i_dec,
  input  logic i_is_win,
  output logic o_nz
);
  localparam logic [3:0] WEFF = (W == 4'd0) ? 4'd1 : W;

  logic [3:0] r_credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_credit <= WEFF;
    else if (i_reload) r_credit <= i_is_win ? WEFF - 4'd1 : WEFF;
    else if (i_dec)    r_credit <= r_credit - 4'd1;
  end

  assign o_nz = (r_credit != 4'd0);
endmodule

module port_wrr_scheduler #(
  parameter int              NQ      = 8,
  parameter logic [NQ*4-1:0] WEIGHTS = {4'd8,4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NQ-1:0]         q_nonempty,
  input  logic                  wrr_en,
  input  logic                  ready,
  input  logic                  pkt_done,
  output logic                  sel_vld,
  output logic [$clog2(NQ)-1:0] sel_q,
  output logic                  busy,
  output logic                  round_restart
);
  localparam int QW = $clog2(NQ);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
  state_t r_state;

  logic [NQ-1:0] w_cred_nz;
  logic [NQ-1:0] w_elig;
  logic [NQ-1:0] w_pick_vec;
  logic          w_take;
  logic          w_reload;
  logic [QW-1:0] w_win;

  assign w_elig   = q_nonempty & w_cred_nz;
  assign w_take   = (r_state == IDLE) && ready && (|q_nonempty);
  // Every nonempty queue has spent its credit: start a fresh round.
  assign w_reload = wrr_en && (w_elig == '0);
  assign w_pick_vec = (wrr_en && !w_reload) ? w_elig : q_nonempty;

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NQ; i++)
      if (w_pick_vec[i]) w_win = QW'(i);
  end

  genvar g;
  generate
    for (g = 0; g < NQ; g++) begin : g_cred
      wrr_credit_cell #(.W(WEIGHTS[g*4+:4])) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_reload (w_take && w_reload),
        .i_dec    (w_take && wrr_en && !w_reload && (w_win == QW'(g))),
        .i_is_win (w_win == QW'(g)),
        .o_nz     (w_cred_nz[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      sel_vld       <= 1'b0;
      sel_q         <= '0;
      busy          <= 1'b0;
      round_restart <= 1'b0;
    end else begin
      sel_vld       <= 1'b0;
      round_restart <= 1'b0;
      case (r_state)
        IDLE: if (w_take) begin
          r_state       <= GRANT;
          sel_vld       <= 1'b1;
          sel_q         <= w_win;
          busy          <= 1'b1;
          round_restart <= w_reload;
        end
        GRANT: if (pkt_done) begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end else begin
          r_state <= BUSY;
        end
        BUSY: if (pkt_done) begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_port_wrr_scheduler.sv
// Directed bench for port_wrr_scheduler: reset, strict, WRR rounds, lock, gating, mid-packet reset.
module tb_port_wrr_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] q_nonempty;
  logic       wrr_en, ready, pkt_done;
  logic       sel_vld, busy, round_restart;
  logic [2:0] sel_q;

  int total = 0;
  int bad   = 0;

  port_wrr_scheduler dut (
    .clk(clk), .rst_n(rst_n), .q_nonempty(q_nonempty), .wrr_en(wrr_en),
    .ready(ready), .pkt_done(pkt_done), .sel_vld(sel_vld), .sel_q(sel_q),
    .busy(busy), .round_restart(round_restart)
  );

  always #5 clk = ~clk;

  task automatic wait_sel(output logic ok, output logic [2:0] q, output logic rr);
    ok = 1'b0; q = '0; rr = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sel_vld) begin
        ok = 1'b1; q = sel_q; rr = round_restart;
        break;
      end
    end
  endtask

  task automatic finish_pkt(input int n, input logic stop);
    repeat (n) @(negedge clk);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    if (stop) ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; q_nonempty = 8'hFF; ready = 1'b1; wrr_en = 1'b0; pkt_done = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (sel_vld !== 1'b0) begin bad++; $display("FAIL reset_sel_vld got=%b exp=0", sel_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (sel_q !== 3'd0 || round_restart !== 1'b0) begin
      bad++; $display("FAIL reset_q_rr got=%0d/%b exp=0/0", sel_q, round_restart); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (sel_vld !== 1'b1 || sel_q !== 3'd7) begin
      bad++; $display("FAIL reset_first_grant got=%b/%0d exp=1/7", sel_vld, sel_q); end
    finish_pkt(3, 1'b1);
  endtask

  task automatic test_strict;
    logic ok, rr; logic [2:0] q;
    wrr_en = 1'b0; q_nonempty = 8'h18; ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_sel(ok, q, rr);
      total++; if (!ok || q !== 3'd4) begin
        bad++; $display("FAIL strict_hi k=%0d got=%b/%0d exp=1/4", k, ok, q); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL strict_busy got=%b exp=1", busy); end
      if (k == 2) q_nonempty = 8'h08;
      finish_pkt(5, 1'b0);
    end
    wait_sel(ok, q, rr);
    total++; if (!ok || q !== 3'd3) begin
      bad++; $display("FAIL strict_next got=%b/%0d exp=1/3", ok, q); end
    finish_pkt(5, 1'b1);
  endtask

  task automatic test_packet_lock;
    logic ok, rr; logic [2:0] q;
    wrr_en = 1'b0; q_nonempty = 8'h08; ready = 1'b1;
    wait_sel(ok, q, rr);
    total++; if (!ok || q !== 3'd3) begin
      bad++; $display("FAIL lock_grant got=%b/%0d exp=1/3", ok, q); end
    q_nonempty = 8'h88;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (sel_vld !== 1'b0 || sel_q !== 3'd3 || busy !== 1'b1) begin
        bad++; $display("FAIL lock_hold c=%0d got=%b/%0d/%b exp=0/3/1", c, sel_vld, sel_q, busy); end
    end
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    total++; if (sel_vld !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL lock_gap got=%b/%b exp=0/0", sel_vld, busy); end
    @(negedge clk);
    total++; if (sel_vld !== 1'b1 || sel_q !== 3'd7) begin
      bad++; $display("FAIL lock_next got=%b/%0d exp=1/7", sel_vld, sel_q); end
    finish_pkt(2, 1'b1);
  endtask

  task automatic test_ready_gate;
    int seen = 0;
    q_nonempty = 8'h01; ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sel_vld) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL ready_gate got=%0d exp=0", seen); end
    ready = 1'b1;
    @(negedge clk);
    total++; if (sel_vld !== 1'b1 || sel_q !== 3'd0) begin
      bad++; $display("FAIL ready_rise got=%b/%0d exp=1/0", sel_vld, sel_q); end
    finish_pkt(2, 1'b1);
  endtask

  task automatic test_wrr_round;
    logic ok, rr; logic [2:0] q;
    logic [2:0] exp_q [10] = '{3'd3,3'd3,3'd3,3'd3,3'd0,3'd3,3'd3,3'd3,3'd3,3'd0};
    wrr_en = 1'b1; q_nonempty = 8'h09; ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_sel(ok, q, rr);
      total++; if (!ok || q !== exp_q[k]) begin
        bad++; $display("FAIL wrr_q k=%0d got=%b/%0d exp=1/%0d", k, ok, q, exp_q[k]); end
      total++; if (rr !== (k == 5)) begin
        bad++; $display("FAIL wrr_restart k=%0d got=%b exp=%b", k, rr, (k == 5)); end
      finish_pkt(2, k == 9);
    end
  endtask

  task automatic test_reset_mid_packet;
    logic ok, rr; logic [2:0] q;
    wrr_en = 1'b1; q_nonempty = 8'h81; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_sel(ok, q, rr);
      total++; if (!ok || q !== 3'd7) begin
        bad++; $display("FAIL pre_reset k=%0d got=%b/%0d exp=1/7", k, ok, q); end
      if (k < 3) finish_pkt(2, 1'b0);
    end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midpkt_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || sel_vld !== 1'b0) begin
      bad++; $display("FAIL midpkt_abort got=%b/%b exp=0/0", busy, sel_vld); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_sel(ok, q, rr);
      total++; if (!ok || q !== ((k < 8) ? 3'd7 : 3'd0)) begin
        bad++; $display("FAIL post_reset k=%0d got=%b/%0d exp=1/%0d", k, ok, q, (k < 8) ? 7 : 0); end
      finish_pkt(1, k == 8);
    end
  endtask

  initial begin
    test_reset;
    test_strict;
    test_packet_lock;
    test_ready_gate;
    test_wrr_round;
    test_reset_mid_packet;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/port_wrr_scheduler.md
Name: port_wrr_scheduler

Overview:
- Per-output-port packet scheduler for the hydra switch. It picks which of the 8 priority queues of one output port supplies the next packet to the read engine.
- Two arbitration modes: weighted round robin (wrr_en=1) or strict priority (wrr_en=0).
- Arbitration is packet-granular: once a queue is granted, it is locked until the read engine reports end of packet.
- One instance per output port (16 in hydra). The instance sits between the queue-status logic and the rd_sop/rd_vld/rd_eop read engine.

Parameters:
- NQ, 8: number of priority queues; queue index = header priority field (3 bits); a higher index is more urgent.
- WEIGHTS, {4'd8,4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1}: packed NQ x 4-bit; WEIGHTS[q*4+:4] = WRR weight of queue q; a value of 0 is treated as 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- q_nonempty  in  NQ  bit q = queue q holds at least one complete packet
- wrr_en  in  1  1 = WRR, 0 = strict priority; sampled only in IDLE
- ready  in  1  downstream port ready to accept a new packet (level)
- pkt_done  in  1  one-cycle pulse from read engine at rd_eop of granted packet
- sel_vld  out  1  one-cycle pulse: sel_q is valid; read engine starts packet
- sel_q  out  3  granted queue index; held stable from sel_vld until pkt_done
- busy  out  1  high from sel_vld cycle until the cycle after pkt_done
- round_restart  out  1  one-cycle pulse when WRR credits are reloaded (debug/verif)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sel_vld=0, sel_q=0, busy=0, round_restart=0.
  - credit[q] = effective weight(q) for all q.
  - Reset mid-packet abandons the grant immediately.
- States: IDLE, GRANT, BUSY.
- IDLE:
  - If ready=1 and q_nonempty!=0, compute the winner combinationally, register it into sel_q, and go to GRANT. Otherwise stay in IDLE.
- GRANT (exactly 1 cycle):
  - sel_vld=1, busy=1.
  - If pkt_done=1 in this cycle, go to IDLE; otherwise go to BUSY.
- BUSY:
  - busy=1, sel_q held.
  - Stay until pkt_done=1, then go to IDLE. busy=0 from the next cycle.
  - q_nonempty and ready are ignored here; no preemption.
- Latency:
  - ready and nonempty sampled in cycle N gives sel_vld in cycle N+1.
  - Minimum gap: pkt_done in cycle M allows the next sel_vld at M+2.
- Strict mode (wrr_en=0):
  - Winner = highest-index set bit of q_nonempty.
  - Credits are untouched.
- WRR mode (wrr_en=1):
  - eligible = q_nonempty & (credit!=0).
  - If eligible!=0: winner = highest-index eligible queue; credit[winner] decrements by 1 at the IDLE->GRANT edge.
  - If eligible==0 (all nonempty queues exhausted): reload every credit to its weight and pulse round_restart in the GRANT cycle. Winner = highest nonempty queue; its credit is loaded to weight-1.
  - Credits of empty queues are not reloaded early and are not forfeited until the next restart.
  - Credit width: 4 bits; a credit never underflows because only a nonzero credit is decremented.
- Mode switch: wrr_en is sampled only at an IDLE decision. Credits persist across strict-mode periods.
- Simultaneous events:
  - pkt_done while in IDLE is ignored.
  - A queue going empty after the decision does not cancel the grant; the read engine owns that case.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset behaviour: hold rst_n=0 with q_nonempty=8'hFF and ready=1 -> sel_vld=0, busy=0. Release rst_n -> sel_vld pulses 1 cycle later with sel_q=7.
2. Strict priority: wrr_en=0, q_nonempty=8'h18, ready=1, pkt_done 5 cycles after each grant -> every grant has sel_q=4. Clear bit 4 -> sel_q=3.
3. WRR round: wrr_en=1, q_nonempty=8'h09 held, default weights -> grant sequence 3,3,3,3,0, then round_restart pulses and the sequence repeats 3,3,3,3,0.
4. Packet lock: grant queue 3, then raise q_nonempty bit 7 during BUSY -> sel_q stays 3 and no sel_vld until pkt_done. Next grant is 7, with sel_vld 2 cycles after pkt_done.
5. Ready gating: q_nonempty=8'h01 with ready=0 for 20 cycles -> no sel_vld. Raise ready -> sel_vld next cycle with sel_q=0.
6. Async reset mid-packet: assert rst_n=0 while in BUSY -> busy=0 immediately. After release, credits are back at full weights (queue 7 gets 8 consecutive grants with q_nonempty=8'h81).
